// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit with AXI4-Lite master; optional store forwarding under LSU_STORE_FWD_EN
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  // execute side
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                ex_load,
  input  logic                ex_store,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_alu_result,
  input  logic [XLEN-1:0]     ex_wdata,
  input  logic [4:0]          ex_rd,
  input  logic                ex_regfile_wr_enable,
  input  logic [1:0]          ex_result_src,
  input  logic [ADDR_W-1:0]   ex_instr_addr_plus,
  // writeback side
  output logic [4:0]          mem_rd,
  output logic                mem_regfile_wr_enable,
  output logic [1:0]          mem_result_src,
  output logic [ADDR_W-1:0]   mem_instr_addr_plus,
  output logic [XLEN-1:0]     mem_alu_result,
  output logic                mem_valid,
  output logic [XLEN-1:0]     mem_rd_data,
  output logic                mem_exc,
  output logic [1:0]          mem_exc_cause,
  // AXI4-Lite master
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [XLEN-1:0]     wdata,
  output logic [XLEN/8-1:0]   wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          rresp
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_B,
    S_RD,
    S_R
  } state_t;

  state_t state_q, state_d;

  logic                accept;
  logic                mem_op;
  logic                size_illegal;
  logic                misaligned;
  logic [ADDR_W-1:0]   ex_addr;
  logic [ADDR_W-1:0]   ex_addr_al;
  logic [OFF_W-1:0]    ex_off;
  logic [STRB_W-1:0]   ex_mask;
  logic                fwd_hit;
  logic [XLEN-1:0]     fwd_rdata;
  logic                aw_done;
  logic                w_done;

  logic [ADDR_W-1:0]   bus_addr_q;
  logic [OFF_W-1:0]    off_q;
  logic [2:0]          f3_q;

  // Byte-enable pattern of an access size before lane shifting.
  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = STRB_W'(1);
      2'd1:    size_mask = STRB_W'(3);
      2'd2:    size_mask = STRB_W'(15);
      default: size_mask = '1;
    endcase
  endfunction

  // Right-align the addressed lanes, then sign- or zero-extend by size.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                               input logic [OFF_W-1:0] off,
                                               input logic [2:0]       f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sgn;
    sh = d >> {off, 3'b000};
    case (f3[1:0])
      2'd0:    begin keep = XLEN'(8'hFF);         sgn = sh[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sgn = sh[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sgn = sh[31];     end
      default: begin keep = '1;                   sgn = sh[XLEN-1]; end
    endcase
    load_ext = (sh & keep) | ({XLEN{sgn & ~f3[2]}} & ~keep);
  endfunction

  assign accept     = ex_valid && (state_q == S_IDLE);
  assign mem_op     = ex_load | ex_store;
  assign ex_addr    = ADDR_W'(ex_alu_result);
  assign ex_addr_al = ex_addr & ~ADDR_W'(STRB_W - 1);
  assign ex_off     = ex_alu_result[OFF_W-1:0];
  assign ex_mask    = size_mask(ex_funct3[1:0]) << ex_off;

  // A doubleword access only exists on a 64-bit datapath.
  assign size_illegal = (XLEN == 32) && (ex_funct3[1:0] == 2'b11);

  // Natural alignment: the low address bits below the access size must be zero.
  always_comb begin
    misaligned = 1'b0;
    case (ex_funct3[1:0])
      2'd1:    misaligned = ex_alu_result[0];
      2'd2:    misaligned = |ex_alu_result[1:0];
      2'd3:    misaligned = |ex_alu_result[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // A channel counts as finished once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid || awready;
  assign w_done  = !wvalid || wready;

  assign awaddr = bus_addr_q;
  assign araddr = bus_addr_q;

`ifdef LSU_STORE_FWD_EN
  logic                fwd_valid_q;
  logic [ADDR_W-1:0]   fwd_addr_q;
  logic [XLEN-1:0]     fwd_data_q;
  logic [STRB_W-1:0]   fwd_strb_q;

  // Only a load whose every byte was written by the last good store is served locally.
  assign fwd_hit   = fwd_valid_q && (fwd_addr_q == ex_addr_al) &&
                     ((ex_mask & ~fwd_strb_q) == '0);
  assign fwd_rdata = fwd_data_q;

  // Remember the last successful store; a failed one leaves nothing trustworthy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      fwd_strb_q  <= '0;
    end else if (state_q == S_B && bvalid) begin
      if (bresp == 2'b00) begin
        fwd_valid_q <= 1'b1;
        fwd_addr_q  <= bus_addr_q;
        fwd_data_q  <= wdata;
        fwd_strb_q  <= wstrb;
      end else begin
        fwd_valid_q <= 1'b0;
      end
    end
  end
`else
  assign fwd_hit   = 1'b0;
  assign fwd_rdata = '0;
`endif

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; bready/rready belong to their wait states only.
  always_comb begin
    state_d  = state_q;
    ex_ready = 1'b0;
    bready   = 1'b0;
    rready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ex_ready = 1'b1;
        if (accept && mem_op && !size_illegal && !misaligned) begin
          if (ex_store) begin
            state_d = S_WR;
          end else if (!fwd_hit) begin
            state_d = S_RD;
          end
        end
      end
      S_WR: begin
        if (aw_done && w_done) begin
          state_d = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (arready) begin
          state_d = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture the instruction on acceptance, drive the bus, return the result.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_rd                <= '0;
      mem_regfile_wr_enable <= 1'b0;
      mem_result_src        <= '0;
      mem_instr_addr_plus   <= '0;
      mem_alu_result        <= '0;
      mem_valid             <= 1'b0;
      mem_rd_data           <= '0;
      mem_exc               <= 1'b0;
      mem_exc_cause         <= '0;
      awvalid               <= 1'b0;
      wvalid                <= 1'b0;
      wdata                 <= '0;
      wstrb                 <= '0;
      arvalid               <= 1'b0;
      bus_addr_q            <= '0;
      off_q                 <= '0;
      f3_q                  <= '0;
    end else begin
      mem_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mem_rd                <= ex_rd;
            mem_regfile_wr_enable <= ex_regfile_wr_enable;
            mem_result_src        <= ex_result_src;
            mem_instr_addr_plus   <= ex_instr_addr_plus;
            mem_alu_result        <= ex_alu_result;
            bus_addr_q            <= ex_addr_al;
            off_q                 <= ex_off;
            f3_q                  <= ex_funct3;
            mem_exc               <= 1'b0;
            mem_exc_cause         <= 2'd0;
            if (!mem_op) begin
              mem_valid <= 1'b1;
            end else if (size_illegal) begin
              mem_valid             <= 1'b1;
              mem_exc               <= 1'b1;
              mem_exc_cause         <= 2'd3;
              mem_regfile_wr_enable <= 1'b0;
            end else if (misaligned) begin
              mem_valid             <= 1'b1;
              mem_exc               <= 1'b1;
              mem_exc_cause         <= ex_store ? 2'd1 : 2'd0;
              mem_regfile_wr_enable <= 1'b0;
            end else if (ex_store) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              wdata   <= ex_wdata << {ex_off, 3'b000};
              wstrb   <= ex_mask;
            end else if (fwd_hit) begin
              mem_valid   <= 1'b1;
              mem_rd_data <= load_ext(fwd_rdata, ex_off, ex_funct3);
            end else begin
              arvalid <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
          end
        end
        S_B: begin
          if (bvalid) begin
            mem_valid <= 1'b1;
            if (bresp != 2'b00) begin
              mem_exc               <= 1'b1;
              mem_exc_cause         <= 2'd2;
              mem_regfile_wr_enable <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (arready) begin
            arvalid <= 1'b0;
          end
        end
        S_R: begin
          if (rvalid) begin
            mem_valid   <= 1'b1;
            mem_rd_data <= load_ext(rdata, off_q, f3_q);
            if (rresp != 2'b00) begin
              mem_exc               <= 1'b1;
              mem_exc_cause         <= 2'd2;
              mem_regfile_wr_enable <= 1'b0;
            end
          end
        end
        default: begin
          awvalid <= 1'b0;
          wvalid  <= 1'b0;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised load/store unit for the memory stage of the Ludi-V pipeline. It sits between execute and writeback and drives a flat AXI4-Lite master port with full valid/ready handshakes. It stalls execute while a bus transaction is outstanding, aligns byte lanes for sub-word accesses and flags misaligned, illegal or failed accesses. Non-memory instructions pass through with one cycle of latency.

## Interface
- XLEN, 32 — datapath width; 32 or 64.
- ADDR_W, 32 — address width.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage accepts; high only in IDLE.
- ex_load, ex_store  in  1  instruction class; both low means non-memory.
- ex_funct3  in  3  RISC-V size/sign code.
- ex_alu_result  in  XLEN  effective address, or ALU result for non-memory ops.
- ex_wdata  in  XLEN  store data, right-aligned.
- ex_rd / ex_regfile_wr_enable / ex_result_src / ex_instr_addr_plus  in  5/1/2/ADDR_W  passthrough bundle.
- mem_rd / mem_regfile_wr_enable / mem_result_src / mem_instr_addr_plus / mem_alu_result  out  5/1/2/ADDR_W/XLEN  registered bundle.
- mem_valid  out  1  one-cycle pulse; result is valid.
- mem_rd_data  out  XLEN  extended load data.
- mem_exc  out  1  exception with mem_valid.
- mem_exc_cause  out  2  0 = load misaligned, 1 = store misaligned, 2 = bus error, 3 = illegal size.
- awvalid/awready/awaddr, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr, rvalid/rready/rdata/rresp — AXI4-Lite master.
  - Data width: XLEN.
  - wstrb width: XLEN/8.
  - resp width: 2.

## Operation
- FSM states: IDLE, WR, B, RD, R.
- Transaction is accepted when ex_valid && ex_ready.
- Non-memory op: bundle registered, mem_valid=1 next cycle, state stays IDLE.
- Check order for a memory op:
  - Size 011 with XLEN=32: cause 3, no bus access.
  - Misaligned address (half: addr[0]; word: addr[1:0]; dword: addr[2:0]): cause 0 for loads, 1 for stores, no bus access.
  - In both cases mem_valid=1 next cycle.
- Store: go to WR.
  - Assert awvalid and wvalid together.
  - awaddr = address aligned down to XLEN/8 bytes.
  - wdata = store data shifted left by 8×addr offset.
  - wstrb = size mask (1/3/F/FF) shifted by the offset.
  - Each valid drops independently on its own handshake.
  - Once both handshakes are done, go to B with bready=1.
  - On bvalid, go to IDLE with mem_valid=1. bresp≠0 sets cause 2.
- Load: go to RD.
  - Assert arvalid with the aligned araddr until arready, then go to R with rready=1.
  - On rvalid: shift rdata right by 8×offset, sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1), register into mem_rd_data, set mem_valid.
  - rresp≠0 sets cause 2.
- Payload is held stable while any valid is high. No valid is dropped before its handshake.
- On an exception, mem_regfile_wr_enable is forced to 0.

## Timing
- Reset values: ex_ready=1; all other outputs 0; state IDLE.
- Reset mid-transaction abandons it immediately. The slave must share aresetn.
- Latency is counted from acceptance at cycle 0:
  - Non-memory op or exception: mem_valid at cycle 1.
  - Load: arvalid at cycle 1; earliest rvalid at cycle 2; mem_valid at cycle 3.
  - Store: awvalid/wvalid at cycle 1; earliest bvalid at cycle 2; mem_valid at cycle 3.
- Each wait cycle on the slave adds exactly one cycle.
- awready and wready may arrive in any order or in the same cycle.
- A bvalid or rvalid in the handshake cycle itself is not accepted; bready/rready assert only in B/R.
- ex_ready=0 in WR/B/RD/R. It returns to 1 in the cycle mem_valid pulses, which allows back-to-back ops.

## Configuration
- LSU_STORE_FWD_EN defined:
  - A one-entry buffer records the aligned address, data and strobes of the last successful store.
  - A following load whose bytes are fully covered by those strobes at the same aligned address skips AR and returns buffered data with mem_valid at cycle 1.
  - Any other load, or an aliasing partial store, is served from the bus.
  - Reset invalidates the entry.
- LSU_STORE_FWD_EN undefined: no buffer; every load goes to the bus.

## Test plan
- XLEN=32, sw 0xDEADBEEF at 0x104, slave always ready → awaddr=0x104, wstrb=1111, wdata=0xDEADBEEF, mem_valid at cycle 3.
- sb 0xA5 at 0x103 → awaddr=0x100, wstrb=1000, wdata[31:24]=0xA5.
- lb at 0x102, rdata=0x00800000 → mem_rd_data=0xFFFFFF80; lbu gives 0x00000080.
- lw at 0x106 → no arvalid, mem_exc=1, cause 0, wr_enable 0, mem_valid at cycle 1.
- Store with awready delayed 3 cycles, wready immediate, bresp=2 → wvalid drops after cycle 1, awvalid held stable, ex_ready low throughout, cause 2; assert aresetn mid-B → all valids are 0 immediately.
- With LSU_STORE_FWD_EN: sw 0x12345678 at 0x200, then lw 0x200 → no arvalid, data 0x12345678 at cycle 1. Without the macro, an AR is issued.
